// File: rtl/phase_pkg.sv
// Shared phase codes, timer FSM encoding and index width for the phase timer slice.
package phase_pkg;

  // Phase codes driven by the phase-sequencing FSM
  localparam logic [1:0] PH_E = 2'b00;
  localparam logic [1:0] PH_A = 2'b01;
  localparam logic [1:0] PH_G = 2'b10;
  localparam logic [1:0] PH_L = 2'b11;

  // Preset index is {state, specific}
  localparam int unsigned PH_IDX_W = 3;
  localparam int unsigned PH_NUM   = 8;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/phase_preset_lut.sv
// phase_preset_lut: maps a {state, specific} index to its phase duration.
// Default build: constant parameter mux.
// With PHASE_TIMER_PROG_EN defined: eight writable preset registers that
// reset to the parameter values.
// Ports:
//   clk, rst_n            clock / async active-low reset (used only when programmable)
//   idx_i   [2:0]         preset index {state, specific}
//   preset_o[W-1:0]       combinational preset for idx_i
//   wr_en_i, wr_addr_i, wr_data_i   preset write port (PHASE_TIMER_PROG_EN only)
module phase_preset_lut
  import phase_pkg::*;
#(
  parameter int unsigned W    = 6,
  parameter int unsigned P_E  = 30,
  parameter int unsigned P_ES = 30,
  parameter int unsigned P_A  = 15,
  parameter int unsigned P_AS = 22,
  parameter int unsigned P_G  = 30,
  parameter int unsigned P_GS = 0,
  parameter int unsigned P_L  = 5,
  parameter int unsigned P_LS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef PHASE_TIMER_PROG_EN
  input  logic                wr_en_i,
  input  logic [PH_IDX_W-1:0] wr_addr_i,
  input  logic [W-1:0]        wr_data_i,
`endif
  input  logic [PH_IDX_W-1:0] idx_i,
  output logic [W-1:0]        preset_o
);

  // Any preset that does not fit in W bits is a configuration error
  localparam bit PRESET_OOR =
    ((P_E >> W) | (P_ES >> W) | (P_A >> W) | (P_AS >> W) |
     (P_G >> W) | (P_GS >> W) | (P_L >> W) | (P_LS >> W)) != 0;

  if (PRESET_OOR) begin : g_preset_range
    $error("phase_preset_lut: a preset parameter does not fit in W bits");
  end

  // Parameter default for a given index
  function automatic logic [W-1:0] default_preset(input logic [PH_IDX_W-1:0] idx);
    logic [W-1:0] v;
    v = '0;
    case (idx)
      {PH_E, 1'b0}: v = W'(P_E);
      {PH_E, 1'b1}: v = W'(P_ES);
      {PH_A, 1'b0}: v = W'(P_A);
      {PH_A, 1'b1}: v = W'(P_AS);
      {PH_G, 1'b0}: v = W'(P_G);
      {PH_G, 1'b1}: v = W'(P_GS);
      {PH_L, 1'b0}: v = W'(P_L);
      {PH_L, 1'b1}: v = W'(P_LS);
      default:      v = '0;
    endcase
    return v;
  endfunction

`ifdef PHASE_TIMER_PROG_EN
  logic [W-1:0] preset_q [PH_NUM];

  // Writable preset file; reset restores the parameter defaults
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PH_NUM); i++) begin
        preset_q[i] <= default_preset(PH_IDX_W'(i));
      end
    end else if (wr_en_i) begin
      preset_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign preset_o = preset_q[idx_i];
`else
  // Constant presets: clock and reset are not needed
  logic unused_ok;
  assign unused_ok = clk ^ rst_n;

  always_comb begin
    preset_o = default_preset(idx_i);
  end
`endif

endmodule

// File: rtl/phase_timer.sv
// phase_timer: loads a per-phase duration on start and counts it down on
// timebase ticks, pulsing expired_o when the phase runs out.
// Optional macro PHASE_TIMER_PROG_EN adds a preset write port.
// Ports:
//   clk, rst_n              clock / async active-low reset
//   tick_i                  timebase enable, one decrement per tick
//   start_i                 load preset for current {state_i, specific_i}
//   abort_i                 cancel countdown, no expiry
//   hold_i                  freeze countdown, ticks discarded
//   state_i[1:0], specific_i  preset index
//   preset_o[W-1:0]         combinational preset for the current index
//   count_o[W-1:0]          remaining ticks (registered)
//   busy_o                  high while running (registered)
//   expired_o               one-cycle expiry pulse (registered)
//   wr_en_i, wr_addr_i[2:0], wr_data_i[W-1:0]  preset writes (PHASE_TIMER_PROG_EN only)
module phase_timer
  import phase_pkg::*;
#(
  parameter int unsigned W    = 6,
  parameter int unsigned P_E  = 30,
  parameter int unsigned P_ES = 30,
  parameter int unsigned P_A  = 15,
  parameter int unsigned P_AS = 22,
  parameter int unsigned P_G  = 30,
  parameter int unsigned P_GS = 0,
  parameter int unsigned P_L  = 5,
  parameter int unsigned P_LS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                hold_i,
  input  logic [1:0]          state_i,
  input  logic                specific_i,
`ifdef PHASE_TIMER_PROG_EN
  input  logic                wr_en_i,
  input  logic [PH_IDX_W-1:0] wr_addr_i,
  input  logic [W-1:0]        wr_data_i,
`endif
  output logic [W-1:0]        preset_o,
  output logic [W-1:0]        count_o,
  output logic                busy_o,
  output logic                expired_o
);

  tmr_state_e   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         expired_d;

  phase_preset_lut #(
    .W(W), .P_E(P_E), .P_ES(P_ES), .P_A(P_A), .P_AS(P_AS),
    .P_G(P_G), .P_GS(P_GS), .P_L(P_L), .P_LS(P_LS)
  ) u_lut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef PHASE_TIMER_PROG_EN
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
`endif
    .idx_i     ({state_i, specific_i}),
    .preset_o  (preset_o)
  );

  // Next state: abort beats start beats tick; a zero preset never enters RUN
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (abort_i) begin
      count_d = '0;
      state_d = TMR_IDLE;
    end else if (start_i) begin
      if (preset_o != '0) begin
        count_d = preset_o;
        state_d = TMR_RUN;
      end else begin
        count_d = '0;
        state_d = TMR_IDLE;
      end
    end else if (state_q == TMR_RUN && tick_i && !hold_i) begin
      if (count_q > W'(1)) begin
        count_d = count_q - W'(1);
      end else begin
        count_d   = '0;
        expired_d = 1'b1;
        state_d   = TMR_IDLE;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TMR_IDLE;
      count_q   <= '0;
      busy_o    <= 1'b0;
      expired_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_o    <= (state_d == TMR_RUN);
      expired_o <= expired_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: expectations queued per step, popped and
// checked after each clock edge.
module tb_phase_timer;

  localparam int unsigned W = 6;

  logic         clk;
  logic         rst_n;
  logic         tick_i, start_i, abort_i, hold_i;
  logic [1:0]   state_i;
  logic         specific_i;
  logic [W-1:0] preset_o, count_o;
  logic         busy_o, expired_o;
`ifdef PHASE_TIMER_PROG_EN
  logic         wr_en_i;
  logic [2:0]   wr_addr_i;
  logic [W-1:0] wr_data_i;
`endif

  phase_timer #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .hold_i     (hold_i),
    .state_i    (state_i),
    .specific_i (specific_i),
`ifdef PHASE_TIMER_PROG_EN
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
`endif
    .preset_o   (preset_o),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .expired_o  (expired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    cnt;
    bit    busy;
    bit    exp;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input bit b, input bit e, input string tag);
    exp_t x;
    x.cnt = c; x.busy = b; x.exp = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".count"},   32'(count_o),   32'(x.cnt));
      chk({x.tag, ".busy"},    32'(busy_o),    32'(x.busy));
      chk({x.tag, ".expired"}, 32'(expired_o), 32'(x.exp));
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, check it
  task automatic step(input bit tk, input bit st, input bit ab, input bit hd,
                      input logic [1:0] s, input bit sp,
                      input int ec, input bit eb, input bit ee, input string tag);
    tick_i = tk; start_i = st; abort_i = ab; hold_i = hd;
    state_i = s; specific_i = sp;
    push(ec, eb, ee, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst_n = 1'b0;
    tick_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; hold_i = 1'b0;
    state_i = 2'b00; specific_i = 1'b0;
`ifdef PHASE_TIMER_PROG_EN
    wr_en_i = 1'b0; wr_addr_i = 3'b000; wr_data_i = '0;
`endif
    #12;
    push(0, 0, 0, "reset");
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational preset table
    state_i = 2'b01; specific_i = 1'b0; #1; chk("preset_A",  32'(preset_o), 32'd15);
    state_i = 2'b01; specific_i = 1'b1; #1; chk("preset_AS", 32'(preset_o), 32'd22);
    state_i = 2'b10; specific_i = 1'b1; #1; chk("preset_GS", 32'(preset_o), 32'd0);
    state_i = 2'b11; specific_i = 1'b0; #1; chk("preset_L",  32'(preset_o), 32'd5);
    state_i = 2'b00; specific_i = 1'b1; #1; chk("preset_ES", 32'(preset_o), 32'd30);

    // Full countdown of phase A
    step(0, 1, 0, 0, 2'b01, 0, 15, 1, 0, "a_start");
    for (int i = 1; i <= 15; i++) begin
      step(1, 0, 0, 0, 2'b01, 0, 15 - i, (i != 15), (i == 15), $sformatf("a_tick%0d", i));
    end
    step(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, "a_after");

    // Untimed phase G specific: start does nothing
    step(0, 1, 0, 0, 2'b10, 1, 0, 0, 0, "g_untimed");
    step(1, 0, 0, 0, 2'b10, 1, 0, 0, 0, "g_untimed_tick");

    // Phase L with hold
    step(0, 1, 0, 0, 2'b11, 0, 5, 1, 0, "l_start");
    step(1, 0, 0, 0, 2'b11, 0, 4, 1, 0, "l_tick1");
    step(1, 0, 0, 0, 2'b11, 0, 3, 1, 0, "l_tick2");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 2'b11, 0, 3, 1, 0, $sformatf("l_hold%0d", i));
    end
    step(0, 0, 0, 0, 2'b11, 0, 3, 1, 0, "l_release");
    step(1, 0, 0, 0, 2'b11, 0, 2, 1, 0, "l_tick3");
    step(1, 0, 0, 0, 2'b11, 0, 1, 1, 0, "l_tick4");
    step(1, 0, 0, 0, 2'b11, 0, 0, 0, 1, "l_tick5");

    // Phase A specific, index changes ignored while running, then abort
    step(0, 1, 0, 0, 2'b01, 1, 22, 1, 0, "as_start");
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 0, (i > 5) ? 2'b00 : 2'b01, 1, 22 - i, 1, 0, $sformatf("as_tick%0d", i));
    end
    step(1, 0, 1, 0, 2'b01, 1, 0, 0, 0, "as_abort");
    step(0, 0, 0, 0, 2'b01, 1, 0, 0, 0, "as_after_abort");

    // Abort beats a simultaneous start
    step(0, 1, 0, 0, 2'b11, 0, 5, 1, 0, "pr_start");
    step(1, 1, 1, 0, 2'b11, 0, 0, 0, 0, "pr_abort_start");

    // Start coincident with the final tick restarts without expiry
    step(0, 1, 0, 0, 2'b11, 0, 5, 1, 0, "fin_start");
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 2'b11, 0, 5 - i, 1, 0, $sformatf("fin_tick%0d", i));
    end
    step(1, 1, 0, 0, 2'b01, 0, 15, 1, 0, "fin_restart");

    // Restart during RUN into the untimed phase drops to IDLE
    step(0, 1, 0, 0, 2'b10, 1, 0, 0, 0, "restart_untimed");

    // Asynchronous reset mid-run
    step(0, 1, 0, 0, 2'b00, 0, 30, 1, 0, "e_start");
    for (int i = 1; i <= 23; i++) begin
      step(1, 0, 0, 0, 2'b00, 0, 30 - i, 1, 0, $sformatf("e_tick%0d", i));
    end
    tick_i = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    push(0, 0, 0, "async_reset");
    #1;
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0, 2'b11, 1, 5, 1, 0, "post_reset_start");
    step(1, 0, 0, 0, 2'b11, 1, 4, 1, 0, "post_reset_tick");

`ifdef PHASE_TIMER_PROG_EN
    step(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, "prog_idle");
    wr_en_i = 1'b1; wr_addr_i = 3'b000; wr_data_i = W'(12);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, "prog_write");
    wr_en_i = 1'b0;
    chk("prog_preset_E", 32'(preset_o), 32'd12);
    step(0, 1, 0, 0, 2'b00, 0, 12, 1, 0, "prog_start");
    wr_en_i = 1'b1; wr_data_i = W'(3);
    step(1, 0, 0, 0, 2'b00, 0, 11, 1, 0, "prog_write_running");
    wr_en_i = 1'b0;
    chk("prog_preset_E_new", 32'(preset_o), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("prog_reset_preset", 32'(preset_o), 32'd30);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
